// File: rtl/router_pkt_tx.sv
// router_pkt_tx: transmits one packet per accepted start request.
// A packet is a header byte {length, addr}, length LFSR payload bytes, and a
// parity byte (XOR of header and payload, optionally inverted). The packet
// then finishes with a single ENDPKT cycle that pulses done.
//
// Ports:
//   clock       single clock, all state updates on posedge
//   reset       synchronous, active-high
//   start       one-cycle send request, sampled only in IDLE
//   addr        destination port, latched on accepted start
//   length      payload byte count (1..63), latched on accepted start
//   seed        payload LFSR seed, latched on accepted start (00 -> 01)
//   bad_parity  invert the parity byte of this packet
//   busy        router back-pressure; holds the current byte while high
//   pkt_valid   high while header/payload bytes are on data_out
//   data_out    packet byte stream
//   tx_active   high in every state except IDLE
//   done        one-cycle pulse in ENDPKT
//   len_err     one-cycle pulse when a zero-length start is rejected
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; rejects length==0 with len_err
// HEADER  | header byte on data_out until the router takes it
// PAYLOAD | LFSR payload bytes, one per non-busy cycle
// PARITY  | parity byte on data_out (pkt_valid low) until taken
// ENDPKT  | done pulse, data_out cleared, back to IDLE next cycle

module router_pkt_tx (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] addr,
    input  logic [5:0] length,
    input  logic [7:0] seed,
    input  logic       bad_parity,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       done,
    output logic       len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_ENDPKT
    } state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] parity;
    logic [5:0] byte_cnt;
    logic [5:0] len_q;
    logic [1:0] addr_q;
    logic       bad_q;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // Parity including the payload byte currently on the bus.
    logic [7:0] parity_upd;
    assign parity_upd = parity ^ lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            lfsr      <= 8'h00;
            parity    <= 8'h00;
            byte_cnt  <= 6'd0;
            len_q     <= 6'd0;
            addr_q    <= 2'd0;
            bad_q     <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            tx_active <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                    tx_active <= 1'b0;
                    if (start) begin
                        if (length == 6'd0) begin
                            len_err <= 1'b1;
                        end else begin
                            addr_q    <= addr;
                            len_q     <= length;
                            bad_q     <= bad_parity;
                            lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
                            byte_cnt  <= 6'd0;
                            parity    <= {length, addr};
                            data_out  <= {length, addr};
                            pkt_valid <= 1'b1;
                            tx_active <= 1'b1;
                            state     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        data_out <= lfsr;
                        state    <= S_PAYLOAD;
                    end else begin
                        data_out <= {len_q, addr_q};
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        parity   <= parity_upd;
                        lfsr     <= lfsr_next(lfsr);
                        byte_cnt <= byte_cnt + 6'd1;
                        if (byte_cnt + 6'd1 == len_q) begin
                            pkt_valid <= 1'b0;
                            data_out  <= bad_q ? ~parity_upd : parity_upd;
                            state     <= S_PARITY;
                        end else begin
                            data_out <= lfsr_next(lfsr);
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        done     <= 1'b1;
                        data_out <= 8'h00;
                        state    <= S_ENDPKT;
                    end
                end
                S_ENDPKT: begin
                    tx_active <= 1'b0;
                    data_out  <= 8'h00;
                    state     <= S_IDLE;
                end
                default: begin
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                    tx_active <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits and the payload length at 6 bits.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to send one packet; sampled only in IDLE.
REQ-005 addr  input  2  destination port (0..2), latched on accepted start.
REQ-006 length  input  6  payload byte count (1..63), latched on accepted start.
REQ-007 seed  input  8  payload LFSR seed, latched on accepted start.
REQ-008 bad_parity  input  1  when set at an accepted start, the packet's parity byte is inverted.
REQ-009 busy  input  1  router back-pressure; while high, no byte advances.
REQ-010 pkt_valid  output  1  high while header and payload bytes are on data_out.
REQ-011 data_out  output  8  packet byte stream (header, payload, parity).
REQ-012 tx_active  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when the parity byte is accepted.
REQ-014 len_err  output  1  one-cycle pulse when a start with length==0 is rejected.

Function
REQ-015 The FSM SHALL have the states IDLE, HEADER, PAYLOAD, PARITY and ENDPKT; all outputs SHALL be registered.
REQ-016 In IDLE with start=1 and length!=0: latch addr, length, seed and bad_parity; go to HEADER on the next cycle.
REQ-017 In IDLE with start=1 and length==0: pulse len_err for one cycle and stay in IDLE.
REQ-018 If addr==3, the block SHALL still send the packet (the router drops it); no error is flagged.
REQ-019 HEADER: data_out={length,addr}, pkt_valid=1; running parity initialised to the header value; go to PAYLOAD on the first cycle with busy=0.
REQ-020 PAYLOAD: data_out=current LFSR value, pkt_valid=1. On each cycle with busy=0: the byte is transferred, parity^=byte, the LFSR advances and byte_cnt increments.
REQ-021 The FSM SHALL go to PARITY after byte_cnt reaches length.
REQ-022 LFSR first value=seed, with seed 8'h00 replaced by 8'h01. Next value={cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
REQ-023 PARITY: pkt_valid=0, data_out=parity, or ~parity if bad_parity was latched; go to ENDPKT when busy=0.
REQ-024 ENDPKT: done=1 for exactly one cycle, data_out=0, then return to IDLE. The earliest next start is accepted in the cycle after ENDPKT.
REQ-025 While busy=1 in any transmitting state, data_out, pkt_valid, the LFSR, parity and byte_cnt SHALL hold unchanged.
REQ-026 start asserted outside IDLE SHALL be ignored and not queued.
REQ-027 Changes on addr, length, seed or bad_parity after an accepted start SHALL not affect the packet in flight.
REQ-028 byte_cnt SHALL be 6 bits; length=63 SHALL send 63 payload bytes with no wrap.
REQ-029 Unstalled packet duration SHALL be length+3 cycles from the first HEADER cycle to done inclusive.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and clear pkt_valid, data_out, tx_active, done, len_err, byte_cnt, parity and the latched fields, in any state.
REQ-031 A packet interrupted by reset SHALL be abandoned, not resumed; a start sampled in the same cycle as reset SHALL be ignored.

Verification
REQ-032 Good packet: start, addr=1, length=3, seed=01, busy=0 -> bytes 0D(pv=1), 01, 02, 04(pv=1), then 0A(pv=0); done pulses one cycle later.
REQ-033 Bad parity: same stimulus with bad_parity=1 -> identical header and payload, parity byte F5.
REQ-034 Stall: busy=1 for 3 cycles while data_out=02 in PAYLOAD -> 02 held 4 cycles, then 04; parity still 0A.
REQ-035 Zero length: start with length=0 -> len_err=1 for one cycle, tx_active stays 0, no bytes sent.
REQ-036 Reset mid-packet: reset during PAYLOAD -> next cycle all outputs 0 and IDLE; a following start sends a fresh header.
REQ-037 Seed 00, length=5 -> payload bytes 01,02,04,08,11; start pulsed during PAYLOAD is ignored.
